dff_response_checker: RTL and testbench

Cycle-accurate response checker for the D flip-flop: the receiving end of the flop's stimulus/response interface. It observes the stimulus applied to the flop (`d`, `rst_l`) and the flop's outputs (`q`, `qbar`), runs a reference model, and counts and flags mismatches. It sits alongside the flop in the verification environment or in on-chip self-test.

---
 rtl/dff_response_checker.sv | 119 +++++++++++
 tb/tb_dff_response_checker.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_response_checker.sv
// Response checker for a D flip-flop: reference model, compare, sticky flags
// and saturating check/error counters with an optional halt on first error.
module dff_response_checker #(
    parameter int unsigned CNT_W       = 16,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d,
    input  logic             rst_l,
    input  logic             q,
    input  logic             qbar,
    output logic             err,
    output logic [1:0]       err_flags,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_at,
    output logic             halted
);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        CHECK,
        HALT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state;
    state_t state_nxt;
    logic   exp_q;
    logic   exp_v;
    logic   qmis;
    logic   cmis;
    logic   mis;
    logic   cmp;

    // The flop resets asynchronously, so a low rst_l overrides the registered model.
    assign exp_v = rst_l ? exp_q : 1'b0;
    assign qmis  = (q !== exp_v);
    assign cmis  = (qbar !== ~q);
    assign mis   = qmis | cmis;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (en) state_nxt = PRIME;
            end
            PRIME: begin
                state_nxt = en ? CHECK : IDLE;
            end
            CHECK: begin
                if (mis && STOP_ON_ERR) begin
                    state_nxt = HALT;
                end else if (!en) begin
                    state_nxt = IDLE;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        cmp    = 1'b0;
        halted = 1'b0;
        unique case (state)
            CHECK:   cmp    = 1'b1;
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q        <= 1'b0;
            err          <= 1'b0;
            err_flags    <= 2'b00;
            chk_cnt      <= '0;
            err_cnt      <= '0;
            first_err_at <= '0;
        end else begin
            exp_q <= rst_l & d;
            err   <= cmp & mis;
            if (cmp) begin
                if (chk_cnt != CNT_MAX) begin
                    chk_cnt <= chk_cnt + CNT_ONE;
                end
                if (mis) begin
                    if (err_cnt != CNT_MAX) begin
                        err_cnt <= err_cnt + CNT_ONE;
                    end
                    err_flags <= err_flags | {cmis, qmis};
                    // err_cnt never wraps, so zero means no error yet.
                    if (err_cnt == '0) begin
                        first_err_at <= chk_cnt;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dff_response_checker.sv
// Scoreboard bench for dff_response_checker: three instances (default,
// halt-on-error, 3-bit counters) driven by one modelled flop.
module tb_dff_response_checker;

    logic clk;
    logic rst;
    logic en;
    logic d;
    logic rst_l;
    logic inj_q;
    logic inj_c;
    logic ff;
    logic q;
    logic qbar;

    logic        a_err;
    logic [1:0]  a_flags;
    logic [15:0] a_chk;
    logic [15:0] a_ecnt;
    logic [15:0] a_first;
    logic        a_halted;

    logic        b_err;
    logic [1:0]  b_flags;
    logic [15:0] b_chk;
    logic [15:0] b_ecnt;
    logic [15:0] b_first;
    logic        b_halted;

    logic        c_err;
    logic [1:0]  c_flags;
    logic [2:0]  c_chk;
    logic [2:0]  c_ecnt;
    logic [2:0]  c_first;
    logic        c_halted;

    typedef struct {
        int       dut;
        string    tag;
        bit       care_err;
        logic     err;
        logic [1:0] flags;
        int       chk;
        int       ecnt;
        int       first;
        logic     halted;
    } exp_t;

    exp_t sb[$];
    int   n_total;
    int   n_pass;

    // Correct flop plus fault injection on q and qbar.
    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) ff <= 1'b0;
        else        ff <= d;
    end

    assign q    = ff ^ inj_q;
    assign qbar = inj_c ? q : ~q;

    dff_response_checker #(.CNT_W(16), .STOP_ON_ERR(1'b0)) u_a (
        .clk(clk), .rst(rst), .en(en), .d(d), .rst_l(rst_l),
        .q(q), .qbar(qbar), .err(a_err), .err_flags(a_flags),
        .chk_cnt(a_chk), .err_cnt(a_ecnt), .first_err_at(a_first),
        .halted(a_halted)
    );

    dff_response_checker #(.CNT_W(16), .STOP_ON_ERR(1'b1)) u_b (
        .clk(clk), .rst(rst), .en(en), .d(d), .rst_l(rst_l),
        .q(q), .qbar(qbar), .err(b_err), .err_flags(b_flags),
        .chk_cnt(b_chk), .err_cnt(b_ecnt), .first_err_at(b_first),
        .halted(b_halted)
    );

    dff_response_checker #(.CNT_W(3), .STOP_ON_ERR(1'b0)) u_c (
        .clk(clk), .rst(rst), .en(en), .d(d), .rst_l(rst_l),
        .q(q), .qbar(qbar), .err(c_err), .err_flags(c_flags),
        .chk_cnt(c_chk), .err_cnt(c_ecnt), .first_err_at(c_first),
        .halted(c_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input string name,
                         input int act, input int want);
        n_total++;
        if (act == want) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s: got %0d, expected %0d", tag, name, act, want);
        end
    endtask

    // Monitor: every expectation queued since the last edge is compared here.
    always @(negedge clk) begin
        exp_t e;
        int   g_err;
        int   g_flags;
        int   g_chk;
        int   g_ecnt;
        int   g_first;
        int   g_halt;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.dut)
                0: begin
                    g_err = int'(a_err); g_flags = int'(a_flags);
                    g_chk = int'(a_chk); g_ecnt = int'(a_ecnt);
                    g_first = int'(a_first); g_halt = int'(a_halted);
                end
                1: begin
                    g_err = int'(b_err); g_flags = int'(b_flags);
                    g_chk = int'(b_chk); g_ecnt = int'(b_ecnt);
                    g_first = int'(b_first); g_halt = int'(b_halted);
                end
                default: begin
                    g_err = int'(c_err); g_flags = int'(c_flags);
                    g_chk = int'(c_chk); g_ecnt = int'(c_ecnt);
                    g_first = int'(c_first); g_halt = int'(c_halted);
                end
            endcase
            if (e.care_err) check(e.tag, "err", g_err, int'(e.err));
            check(e.tag, "err_flags", g_flags, int'(e.flags));
            check(e.tag, "chk_cnt", g_chk, e.chk);
            check(e.tag, "err_cnt", g_ecnt, e.ecnt);
            check(e.tag, "first_err_at", g_first, e.first);
            check(e.tag, "halted", g_halt, int'(e.halted));
        end
    end

    task automatic expect_out(input int dut, input string tag,
                              input bit care_err, input logic err_v,
                              input logic [1:0] fl, input int chk,
                              input int ec, input int fst,
                              input logic hlt);
        exp_t x;
        x.dut = dut; x.tag = tag; x.care_err = care_err;
        x.err = err_v; x.flags = fl; x.chk = chk;
        x.ecnt = ec; x.first = fst; x.halted = hlt;
        sb.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; rst_l = 1'b0;
        d = 1'b0; inj_q = 1'b0; inj_c = 1'b0;
        step();
        step();
        rst = 1'b0; rst_l = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expect_out(k, "reset", 1, 1'b0, 2'b00, 0, 0, 0, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1; en = 1'b0; d = 1'b0; rst_l = 1'b1;
        inj_q = 1'b0; inj_c = 1'b0;
        #1;

        // Clean run with d toggling.
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            d = ~d;
            expect_out(0, "clean", 1, 1'b0, 2'b00, (i >= 3) ? i - 2 : 0, 0, 0, 1'b0);
        end

        // Flop reset pulse with d held high.
        d = 1'b1;
        step(); expect_out(0, "rstl_pre", 1, 1'b0, 2'b00, 9, 0, 0, 1'b0);
        rst_l = 1'b0;
        step(); expect_out(0, "rstl_lo1", 1, 1'b0, 2'b00, 10, 0, 0, 1'b0);
        step(); expect_out(0, "rstl_lo2", 1, 1'b0, 2'b00, 11, 0, 0, 1'b0);
        rst_l = 1'b1;
        step(); expect_out(0, "rstl_hi1", 1, 1'b0, 2'b00, 12, 0, 0, 1'b0);
        step(); expect_out(0, "rstl_hi2", 1, 1'b0, 2'b00, 13, 0, 0, 1'b0);

        // Disable: one last compare, hold, then re-prime.
        en = 1'b0;
        step(); expect_out(0, "dis1", 1, 1'b0, 2'b00, 14, 0, 0, 1'b0);
        step(); expect_out(0, "dis2", 1, 1'b0, 2'b00, 14, 0, 0, 1'b0);
        en = 1'b1;
        step(); expect_out(0, "ren1", 1, 1'b0, 2'b00, 14, 0, 0, 1'b0);
        step(); expect_out(0, "ren2", 1, 1'b0, 2'b00, 14, 0, 0, 1'b0);
        step(); expect_out(0, "ren3", 1, 1'b0, 2'b00, 15, 0, 0, 1'b0);

        // q inverted for the compare with chk_cnt = 5.
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            d = ~d;
            inj_q = (i == 7);
            if (i < 8)
                expect_out(0, "qinv", 1, 1'b0, 2'b00, (i >= 3) ? i - 2 : 0, 0, 0, 1'b0);
            else if (i == 8)
                expect_out(0, "qinv_hit", 1, 1'b1, 2'b01, 6, 1, 5, 1'b0);
            else
                expect_out(0, "qinv_post", 1, 1'b0, 2'b01, i - 2, 1, 5, 1'b0);
        end

        // qbar equal to q for three compares.
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            d = ~d;
            inj_c = (i >= 4 && i <= 6);
            if (i < 5)
                expect_out(0, "comp", 1, 1'b0, 2'b00, (i >= 3) ? i - 2 : 0, 0, 0, 1'b0);
            else if (i <= 7)
                expect_out(0, "comp_hit", 1, 1'b1, 2'b10, i - 2, i - 4, 2, 1'b0);
            else
                expect_out(0, "comp_post", 1, 1'b0, 2'b10, 6, 3, 2, 1'b0);
        end

        // Halt on first error, frozen afterwards, cleared by rst.
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            d = ~d;
            inj_q = (i == 5 || i == 9);
            if (i < 6)
                expect_out(1, "stop", 1, 1'b0, 2'b00, (i >= 3) ? i - 2 : 0, 0, 0, 1'b0);
            else if (i == 6)
                expect_out(1, "stop_hit", 1, 1'b1, 2'b01, 4, 1, 3, 1'b1);
            else
                expect_out(1, "halt_hold", 0, 1'b0, 2'b01, 4, 1, 3, 1'b1);
        end
        do_reset();
        step();
        expect_out(1, "halt_exit", 1, 1'b0, 2'b00, 0, 0, 0, 1'b0);

        // 3-bit counters with q and qbar both wrong every compare.
        do_reset();
        en = 1'b1;
        inj_q = 1'b1;
        inj_c = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (i == 3)  expect_out(2, "sat_c1", 1, 1'b1, 2'b11, 1, 1, 0, 1'b0);
            if (i == 5)  expect_out(2, "sat_c3", 1, 1'b1, 2'b11, 3, 3, 0, 1'b0);
            if (i == 9)  expect_out(2, "sat_c7", 1, 1'b1, 2'b11, 7, 7, 0, 1'b0);
            if (i == 14) expect_out(2, "sat_end", 1, 1'b1, 2'b11, 7, 7, 0, 1'b0);
        end
        inj_q = 1'b0;
        inj_c = 1'b0;

        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
